// File: rtl/mem_bus_bridge.sv
// Purpose: data-memory bridge from the single-cycle MEM stage to a handshaked 64-bit bus; one transaction in flight.
// Latency: stall covers IDLE, REQ and RESP (3 cycles minimum); load data and MEM_Error are presented in DONE.
// Backpressure: holds REQ while bus_req_ready is low and RESP until bus_resp_valid; the core is stalled throughout.
// Ports: clk/rst (async, active-low); MEM_* core side (request in, Datainput/Stall/Error out);
//        bus_req_* valid/ready request channel; bus_resp_* response channel (valid, data, err).
// Option: define MEM_BUS_BRIDGE_TIMEOUT_EN to abort after TIMEOUT_CYCLES cycles in REQ/RESP with an error.
module mem_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_Enable,
   input  logic        MEM_Read,
   input  logic [3:0]  MEM_DataLenth,
   input  logic [63:0] MEM_Addr,
   input  logic [63:0] MEM_Dataoutput,
   output logic [63:0] MEM_Datainput,
   output logic        MEM_Stall,
   output logic        MEM_Error,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_write,
   output logic [63:0] bus_req_addr,
   output logic [63:0] bus_req_wdata,
   output logic [7:0]  bus_req_wstrb,
   input  logic        bus_resp_valid,
   input  logic [63:0] bus_resp_data,
   input  logic        bus_resp_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  off;
   logic [3:0]  len_m1;
   logic        len_ok;
   logic        legal;
   logic        capture;
   logic [7:0]  strb_base;
   logic [2:0]  off_q;
   logic [3:0]  len_q;
   logic        err_flag;
   logic [63:0] rd_shift;
   logic [63:0] rd_mask;
   logic        timeout;
   logic        timeout_hit;

   assign off    = MEM_Addr[2:0];
   assign len_m1 = MEM_DataLenth - 4'd1;
   assign len_ok = (MEM_DataLenth == 4'd1) || (MEM_DataLenth == 4'd2) ||
                   (MEM_DataLenth == 4'd4) || (MEM_DataLenth == 4'd8);
   // For power-of-two sizes, natural alignment means the low address bits under the size are zero.
   assign legal   = MEM_Enable && len_ok && ((off & len_m1[2:0]) == 3'd0);
   assign capture = (state == IDLE) && legal;

   always_comb begin
      strb_base = 8'h01;
      case (MEM_DataLenth)
         4'd2:    strb_base = 8'h03;
         4'd4:    strb_base = 8'h0F;
         4'd8:    strb_base = 8'hFF;
         default: strb_base = 8'h01;
      endcase
   end

   // Load path: bring the addressed bytes down to lane 0, then clear everything above the access size.
   assign rd_shift = bus_resp_data >> {off_q, 3'b000};
   always_comb begin
      rd_mask = 64'h0000_0000_0000_00FF;
      case (len_q)
         4'd2:    rd_mask = 64'h0000_0000_0000_FFFF;
         4'd4:    rd_mask = 64'h0000_0000_FFFF_FFFF;
         4'd8:    rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
         default: rd_mask = 64'h0000_0000_0000_00FF;
      endcase
   end

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
   logic [15:0] tcnt;

   // >= rather than == so a REQ handshake landing on the limit still times out in the next RESP cycle.
   assign timeout = ((state == REQ) || (state == RESP)) && (tcnt >= 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt <= 16'd0;
      end else if (capture) begin
         tcnt <= 16'd0;
      end else if (((state == REQ) || (state == RESP)) && (tcnt != 16'hFFFF)) begin
         tcnt <= tcnt + 16'd1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // A timeout only aborts when neither the handshake (REQ) nor the response (RESP) arrives that cycle.
   assign timeout_hit = timeout &&
                        (((state == REQ) && !bus_req_ready) || ((state == RESP) && !bus_resp_valid));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (legal) state_nxt = REQ;
         REQ: begin
            if (bus_req_ready)    state_nxt = RESP;
            else if (timeout_hit) state_nxt = DONE;
         end
         RESP: if (bus_resp_valid || timeout_hit) state_nxt = DONE;
         // Any MEM_Enable seen here still belongs to the instruction that just completed.
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req_addr  <= 64'd0;
         bus_req_wdata <= 64'd0;
         bus_req_wstrb <= 8'd0;
         bus_req_write <= 1'b0;
         off_q         <= 3'd0;
         len_q         <= 4'd0;
         err_flag      <= 1'b0;
         MEM_Datainput <= 64'd0;
      end else begin
         if (capture) begin
            bus_req_addr  <= {MEM_Addr[63:3], 3'b000};
            bus_req_wdata <= MEM_Dataoutput << {off, 3'b000};
            bus_req_wstrb <= MEM_Read ? 8'd0 : (strb_base << off);
            bus_req_write <= !MEM_Read;
            off_q         <= off;
            len_q         <= MEM_DataLenth;
            err_flag      <= 1'b0;
         end
         if ((state == RESP) && bus_resp_valid) begin
            if (bus_resp_err) begin
               MEM_Datainput <= 64'd0;
               err_flag      <= 1'b1;
            end else if (!bus_req_write) begin
               MEM_Datainput <= rd_shift & rd_mask;
            end
         end else if (timeout_hit) begin
            MEM_Datainput <= 64'd0;
            err_flag      <= 1'b1;
         end
         if (state == DONE) err_flag <= 1'b0;
      end
   end

   assign bus_req_valid = (state == REQ);
   assign MEM_Stall     = ((state == IDLE) && legal) || (state == REQ) || (state == RESP);
   assign MEM_Error     = ((state == IDLE) && MEM_Enable && !legal) || ((state == DONE) && err_flag);

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Purpose: self-checking bench for mem_bus_bridge driving both the core side and a scripted bus responder.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
// Backpressure: ready/response delays come from each scenario; expected requests and results go through queues.
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_Enable, MEM_Read;
   logic [3:0]  MEM_DataLenth;
   logic [63:0] MEM_Addr, MEM_Dataoutput, MEM_Datainput;
   logic        MEM_Stall, MEM_Error;
   logic        bus_req_valid, bus_req_ready, bus_req_write;
   logic [63:0] bus_req_addr, bus_req_wdata;
   logic [7:0]  bus_req_wstrb;
   logic        bus_resp_valid, bus_resp_err;
   logic [63:0] bus_resp_data;

   int checks = 0;
   int errors = 0;
   logic [63:0] hold = 64'd0;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        write;
   } req_t;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } rsp_t;

   req_t exp_req_q[$];
   rsp_t exp_rsp_q[$];

   always #5 clk = ~clk;

   mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .MEM_Enable(MEM_Enable), .MEM_Read(MEM_Read), .MEM_DataLenth(MEM_DataLenth),
      .MEM_Addr(MEM_Addr), .MEM_Dataoutput(MEM_Dataoutput), .MEM_Datainput(MEM_Datainput),
      .MEM_Stall(MEM_Stall), .MEM_Error(MEM_Error),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_write(bus_req_write),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
      .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .bus_resp_err(bus_resp_err)
   );

   function automatic logic [7:0] m_strb(input logic [3:0] len, input logic [2:0] off);
      logic [7:0] s;
      int o, l;
      o = int'(off);
      l = int'(len);
      for (int i = 0; i < 8; i++) s[i] = (i >= o) && (i < o + l);
      return s;
   endfunction

   function automatic logic [63:0] m_rdata(input logic [63:0] d, input logic [3:0] len, input logic [2:0] off);
      logic [63:0] r;
      r = 64'd0;
      for (int i = 0; i < int'(len); i++) r[8*i +: 8] = d[8*(int'(off) + i) +: 8];
      return r;
   endfunction

   task automatic do_access(input logic rd, input logic [3:0] len, input logic [63:0] addr,
                            input logic [63:0] wd, input int rdy_dly, input int rsp_dly,
                            input logic [63:0] rsp_data, input logic rsp_err, input string tag);
      req_t er, gr;
      rsp_t ed;
      int   stall_cnt;
      int   cyc;
      er.addr  = {addr[63:3], 3'b000};
      er.write = !rd;
      er.wstrb = rd ? 8'd0 : m_strb(len, addr[2:0]);
      er.wdata = wd << (8 * int'(addr[2:0]));
      if (rsp_err)  ed.data = 64'd0;
      else if (rd)  ed.data = m_rdata(rsp_data, len, addr[2:0]);
      else          ed.data = hold;
      ed.err = rsp_err;
      exp_req_q.push_back(er);
      exp_rsp_q.push_back(ed);
      stall_cnt = 0;
      // IDLE: request presented, accepted combinationally
      @(posedge clk); #1;
      MEM_Enable = 1'b1; MEM_Read = rd; MEM_DataLenth = len; MEM_Addr = addr; MEM_Dataoutput = wd;
      #1;
      checks++;
      if (MEM_Stall !== 1'b1 || MEM_Error !== 1'b0 || bus_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_accept: stall=%b err=%b valid=%b, want 1 0 0", tag, MEM_Stall, MEM_Error, bus_req_valid);
      end
      if (MEM_Stall === 1'b1) stall_cnt++;
      // REQ: fields must match and stay stable while ready is withheld
      er = exp_req_q.pop_front();
      cyc = 0;
      do begin
         @(posedge clk); #1;
         bus_req_ready = (cyc >= rdy_dly);
         #1;
         gr = '{bus_req_addr, bus_req_wdata, bus_req_wstrb, bus_req_write};
         checks++;
         if (bus_req_valid !== 1'b1 || MEM_Stall !== 1'b1) begin
            errors++;
            $display("FAIL %s req_state c%0d: valid=%b stall=%b, want 1 1", tag, cyc, bus_req_valid, MEM_Stall);
         end
         checks++;
         if (gr !== er) begin
            errors++;
            $display("FAIL %s req_fields c%0d: got addr=%h wdata=%h strb=%h wr=%b, want addr=%h wdata=%h strb=%h wr=%b",
                     tag, cyc, gr.addr, gr.wdata, gr.wstrb, gr.write, er.addr, er.wdata, er.wstrb, er.write);
         end
         if (MEM_Stall === 1'b1) stall_cnt++;
         cyc++;
      end while (cyc <= rdy_dly);
      // RESP
      for (int i = 0; i <= rsp_dly; i++) begin
         @(posedge clk); #1;
         bus_req_ready = 1'b0;
         if (i == rsp_dly) begin
            bus_resp_valid = 1'b1; bus_resp_data = rsp_data; bus_resp_err = rsp_err;
         end
         #1;
         checks++;
         if (bus_req_valid !== 1'b0 || MEM_Stall !== 1'b1) begin
            errors++;
            $display("FAIL %s resp_state: valid=%b stall=%b, want 0 1", tag, bus_req_valid, MEM_Stall);
         end
         if (MEM_Stall === 1'b1) stall_cnt++;
      end
      // DONE: enable still held by the core and must be ignored
      @(posedge clk); #1;
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0; bus_resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
      #1;
      ed = exp_rsp_q.pop_front();
      checks++;
      if (MEM_Stall !== 1'b0 || MEM_Error !== ed.err || bus_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s done_flags: stall=%b err=%b valid=%b, want 0 %b 0", tag, MEM_Stall, MEM_Error, bus_req_valid, ed.err);
      end
      checks++;
      if (MEM_Datainput !== ed.data) begin
         errors++;
         $display("FAIL %s done_data: got %h want %h", tag, MEM_Datainput, ed.data);
      end
      checks++;
      if (stall_cnt != 3 + rdy_dly + rsp_dly) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cnt, 3 + rdy_dly + rsp_dly);
      end
      hold = ed.data;
      // Back in IDLE: no new transaction, error pulse gone, data held
      @(posedge clk); #1;
      MEM_Enable = 1'b0;
      #1;
      checks++;
      if (MEM_Stall !== 1'b0 || bus_req_valid !== 1'b0 || MEM_Error !== 1'b0 || MEM_Datainput !== hold) begin
         errors++;
         $display("FAIL %s after_done: stall=%b valid=%b err=%b data=%h, want 0 0 0 %h",
                  tag, MEM_Stall, bus_req_valid, MEM_Error, MEM_Datainput, hold);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      MEM_Enable = 1'b0; MEM_Read = 1'b0; MEM_DataLenth = 4'd0; MEM_Addr = 64'd0; MEM_Dataoutput = 64'd0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = 64'd0; bus_resp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({MEM_Datainput, MEM_Stall, MEM_Error, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h stall=%b err=%b valid=%b wr=%b addr=%h wdata=%h strb=%h, want all 0",
                  MEM_Datainput, MEM_Stall, MEM_Error, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb);
      end
      rst = 1'b1;
   endtask

   task automatic test_aligned_load();
      do_access(1'b1, 4'd8, 64'h0000_0000_8000_0010, 64'd0, 0, 0, 64'h1122_3344_5566_7788, 1'b0, "aligned_load");
      checks++;
      if (hold !== 64'h1122_3344_5566_7788) begin
         errors++;
         $display("FAIL aligned_load_value: got %h want 1122334455667788", MEM_Datainput);
      end
   endtask

   task automatic test_byte_store();
      do_access(1'b0, 4'd1, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 0, 0, 64'd0, 1'b0, "byte_store");
   endtask

   task automatic test_halfword_load();
      do_access(1'b1, 4'd2, 64'h0000_0000_8000_0106, 64'd0, 0, 1, 64'hBEEF_0000_0000_0000, 1'b0, "halfword_load");
      checks++;
      if (MEM_Datainput !== 64'h0000_0000_0000_BEEF) begin
         errors++;
         $display("FAIL halfword_value: got %h want 000000000000beef", MEM_Datainput);
      end
   endtask

   task automatic test_misaligned();
      logic [3:0]  lens  [3] = '{4'd4, 4'd3, 4'd8};
      logic [63:0] addrs [3] = '{64'h8000_0102, 64'h8000_0100, 64'h8000_0104};
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         MEM_Enable = 1'b1; MEM_Read = k[0]; MEM_DataLenth = lens[k]; MEM_Addr = addrs[k];
         #1;
         checks++;
         if (MEM_Error !== 1'b1 || MEM_Stall !== 1'b0 || bus_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_%0d: err=%b stall=%b valid=%b, want 1 0 0", k, MEM_Error, MEM_Stall, bus_req_valid);
         end
         @(posedge clk); #1;
         MEM_Enable = 1'b0;
         #1;
         checks++;
         if (bus_req_valid !== 1'b0 || MEM_Stall !== 1'b0 || MEM_Error !== 1'b0 || MEM_Datainput !== hold) begin
            errors++;
            $display("FAIL misaligned_after_%0d: valid=%b stall=%b err=%b data=%h, want 0 0 0 %h",
                     k, bus_req_valid, MEM_Stall, MEM_Error, MEM_Datainput, hold);
         end
      end
   endtask

   task automatic test_backpressure_err();
      do_access(1'b1, 4'd4, 64'h0000_0000_8000_0204, 64'd0, 5, 0, 64'h0123_4567_89AB_CDEF, 1'b1, "backpressure_err");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 12; n++) begin
         logic [3:0]  len;
         logic [2:0]  off;
         logic [63:0] a;
         int sel;
         sel = $urandom_range(0, 3);
         len = 4'd1 << sel;
         off = 3'($urandom_range(0, 7)) & ~(3'(len - 4'd1));
         a   = {$urandom, $urandom};
         a[2:0] = off;
         do_access(1'($urandom_range(0, 1)), len, a, {$urandom, $urandom}, $urandom_range(0, 2),
                   $urandom_range(0, 2), {$urandom, $urandom}, ($urandom_range(0, 7) == 0), "back_to_back");
      end
   endtask

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      do_access(1'b1, 4'd8, 64'h8000_0300, 64'd0, 0, 0, 64'hA5A5_0000_5A5A_FFFF, 1'b0, "pre_timeout");
      @(posedge clk); #1;
      MEM_Enable = 1'b1; MEM_Read = 1'b1; MEM_DataLenth = 4'd8; MEM_Addr = 64'h8000_0308;
      bus_req_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         checks++;
         if (bus_req_valid !== 1'b1 || MEM_Stall !== 1'b1) begin
            errors++;
            $display("FAIL timeout_wait c%0d: valid=%b stall=%b, want 1 1", c, bus_req_valid, MEM_Stall);
         end
      end
      @(posedge clk); #2;
      checks++;
      if (MEM_Error !== 1'b1 || MEM_Stall !== 1'b0 || bus_req_valid !== 1'b0 || MEM_Datainput !== 64'd0) begin
         errors++;
         $display("FAIL timeout_done: err=%b stall=%b valid=%b data=%h, want 1 0 0 0",
                  MEM_Error, MEM_Stall, bus_req_valid, MEM_Datainput);
      end
      MEM_Enable = 1'b0;
      hold = 64'd0;
   endtask
`endif

   task automatic test_reset_mid();
      do_access(1'b0, 4'd8, 64'h8000_0400, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'd0, 1'b0, "pre_reset_store");
      @(posedge clk); #1;
      MEM_Enable = 1'b1; MEM_Read = 1'b1; MEM_DataLenth = 4'd8; MEM_Addr = 64'h8000_0408;
      @(posedge clk); #1;
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      #1;
      checks++;
      if (MEM_Stall !== 1'b1 || bus_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_in_resp: stall=%b valid=%b, want 1 0", MEM_Stall, bus_req_valid);
      end
      MEM_Enable = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({MEM_Datainput, MEM_Stall, MEM_Error, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: data=%h stall=%b err=%b valid=%b wr=%b addr=%h wdata=%h strb=%h, want all 0",
                  MEM_Datainput, MEM_Stall, MEM_Error, bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_wstrb);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      bus_resp_valid = 1'b1; bus_resp_data = 64'h7777_7777_7777_7777; bus_resp_err = 1'b1;
      @(posedge clk); #1;
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (MEM_Datainput !== 64'd0 || MEM_Stall !== 1'b0 || MEM_Error !== 1'b0 || bus_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_late_resp: data=%h stall=%b err=%b valid=%b, want 0 0 0 0",
                  MEM_Datainput, MEM_Stall, MEM_Error, bus_req_valid);
      end
      hold = 64'd0;
   endtask

   initial begin
      test_reset();
      test_aligned_load();
      test_byte_store();
      test_halfword_load();
      test_misaligned();
      test_backpressure_err();
      test_back_to_back();
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      checks++;
      if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d requests and %0d results left, want 0 0", exp_req_q.size(), exp_rsp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
